// File: rtl/jt49_eg_pkg.sv
// Shared definitions for the PSG envelope front end: register addresses and R13 bit positions.
package jt49_eg_pkg;

  localparam logic [3:0] ADDR_EP_LO = 4'd11;
  localparam logic [3:0] ADDR_EP_HI = 4'd12;
  localparam logic [3:0] ADDR_SHAPE = 4'd13;

  localparam int CONT = 3;
  localparam int ATT  = 2;
  localparam int ALT  = 1;
  localparam int HOLD = 0;

endpackage

// File: rtl/jt49_eg_div.sv
// Envelope divider: cen prescaler, period counter and the step square wave.
module jt49_eg_div #(
  parameter int PRESC_W = 3,
  parameter int PER_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cen,
  input  logic             clr,
  input  logic [PER_W-1:0] per,
  output logic             step
);

  logic [PRESC_W-1:0] presc;
  logic [PER_W-1:0]   cnt;
  logic [PER_W:0]     cnt_inc;
  logic               tick;
  logic               expire;

  assign tick    = cen && (presc == {PRESC_W{1'b1}});
  // Extra bit keeps cnt+1 from wrapping; >= lets a shrunk period expire at once.
  assign cnt_inc = {1'b0, cnt} + (PER_W + 1)'(1);
  assign expire  = cnt_inc >= {1'b0, per};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc <= '0;
      cnt   <= '0;
      step  <= 1'b0;
    end else if (clr) begin
      presc <= '0;
      cnt   <= '0;
      step  <= 1'b0;
    end else begin
      if (cen) presc <= presc + PRESC_W'(1);
      if (tick) begin
        if (expire) begin
          cnt  <= '0;
          step <= ~step;
        end else begin
          cnt  <= cnt_inc[PER_W-1:0];
        end
      end
    end
  end

endmodule

// File: rtl/jt49_eg_timer.sv
// Envelope front end: R11/R12 period and R13 shape registers, restart pulse, step divider.
// Optional readback port enabled by defining JT49_EG_RDBK_EN.
module jt49_eg_timer
  import jt49_eg_pkg::*;
#(
  parameter int PRESC_W = 3,
  parameter int PER_W   = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cen,
  input  logic       wr,
  input  logic [3:0] addr,
  input  logic [7:0] din,
  output logic       step,
  output logic       null_period,
  output logic       restart,
  output logic [3:0] ctrl
`ifdef JT49_EG_RDBK_EN
  ,
  output logic [7:0] dout
`endif
);

  logic [PER_W-1:0] per;
  logic [PER_W-1:0] per_nxt;
  logic             shape_wr;

  assign shape_wr = wr && (addr == ADDR_SHAPE);

  always_comb begin
    per_nxt = per;
    if (wr && addr == ADDR_EP_LO) per_nxt[7:0]  = din;
    if (wr && addr == ADDR_EP_HI) per_nxt[15:8] = din;
  end

  // null_period tracks the value being written so it lands together with per.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      per         <= '0;
      ctrl        <= 4'h0;
      restart     <= 1'b0;
      null_period <= 1'b1;
    end else begin
      per         <= per_nxt;
      null_period <= (per_nxt == '0);
      restart     <= shape_wr;
      if (shape_wr) ctrl <= {din[CONT], din[ATT], din[ALT], din[HOLD]};
    end
  end

`ifdef JT49_EG_RDBK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout <= 8'h00;
    end else begin
      case (addr)
        ADDR_EP_LO: dout <= per[7:0];
        ADDR_EP_HI: dout <= per[15:8];
        ADDR_SHAPE: dout <= {4'h0, ctrl};
        default:    dout <= 8'h00;
      endcase
    end
  end
`endif

  jt49_eg_div #(
    .PRESC_W (PRESC_W),
    .PER_W   (PER_W)
  ) u_div (
    .clk   (clk),
    .rst_n (rst_n),
    .cen   (cen),
    .clr   (shape_wr),
    .per   (per),
    .step  (step)
  );

endmodule
